// File: rtl/spi_flash_read_seq_if.sv
// Wishbone register-port bus between the flash read sequencer and simple_spi.
// The master drives the strobe/address/write side; the slave returns read data and ack.
interface spi_flash_read_seq_if;
   logic       m_cyc_o;
   logic       m_stb_o;
   logic       m_we_o;
   logic [2:0] m_adr_o;
   logic [7:0] m_dat_o;
   logic [7:0] m_dat_i;
   logic       m_ack_i;

   modport master (
      output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
      input  m_dat_i, m_ack_i
   );

   modport slave (
      input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
      output m_dat_i, m_ack_i
   );
endinterface

// File: rtl/spi_flash_read_seq.sv
// SPI-flash READ (0x03) sequencer over simple_spi: one WB access in flight, one byte in flight.
// Bus accesses start the edge after the state is entered; the payload stream holds while rd_ready_i is low.
module spi_flash_read_seq #(
   parameter int         LEN_W    = 16,
   parameter int         SS_IDX   = 0,
   parameter logic [7:0] SPCR_CFG = 8'h40,
   parameter logic [7:0] SPER_CFG = 8'h00
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [23:0]          req_addr_i,
   input  logic [LEN_W-1:0]     req_len_i,
   output logic                 rd_valid_o,
   input  logic                 rd_ready_i,
   output logic [7:0]           rd_data_o,
   output logic                 done_o,
   spi_flash_read_seq_if.master bus
);

   typedef enum logic [3:0] {
      S_CFG_SPCR, S_CFG_SPER, S_IDLE, S_SS_ON, S_TX,
      S_POLL, S_RX, S_OUT, S_SS_OFF, S_DONE
   } state_t;

   localparam logic [2:0] ADR_SPCR = 3'd0;
   localparam logic [2:0] ADR_SPSR = 3'd1;
   localparam logic [2:0] ADR_SPDR = 3'd2;
   localparam logic [2:0] ADR_SPER = 3'd3;
   localparam logic [2:0] ADR_SS   = 3'd4;
   localparam logic [7:0] SS_MASK  = 8'h01 << SS_IDX;

   state_t           state_q, state_d;
   logic             cyc_q, we_q;
   logic [2:0]       adr_q;
   logic [7:0]       dat_q;
   logic [23:0]      addr_q;
   logic [LEN_W-1:0] rem_q;
   logic [2:0]       k_q;
   logic [7:0]       rd_data_q;

   logic             acc_req, acc_we, ack_ok;
   logic [2:0]       acc_adr;
   logic [7:0]       acc_dat, tx_byte;

   assign ack_ok = cyc_q & bus.m_ack_i;

   always_comb begin
      tx_byte = 8'h00;
      case (k_q)
         3'd0:    tx_byte = 8'h03;
         3'd1:    tx_byte = addr_q[23:16];
         3'd2:    tx_byte = addr_q[15:8];
         3'd3:    tx_byte = addr_q[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      acc_req = 1'b0;
      acc_we  = 1'b0;
      acc_adr = 3'd0;
      acc_dat = 8'h00;
      case (state_q)
         S_CFG_SPCR: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPCR; acc_dat = SPCR_CFG;
            if (ack_ok) state_d = S_CFG_SPER;
         end
         S_CFG_SPER: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPER; acc_dat = SPER_CFG;
            if (ack_ok) state_d = S_IDLE;
         end
         S_IDLE: if (req_valid_i) state_d = S_SS_ON;
         S_SS_ON: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SS; acc_dat = SS_MASK;
            if (ack_ok) state_d = S_TX;
         end
         S_TX: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPDR; acc_dat = tx_byte;
            if (ack_ok) state_d = S_POLL;
         end
         S_POLL: begin
            // SPSR bit0 is rfempty: keep polling until the exchanged byte lands
            acc_req = 1'b1; acc_adr = ADR_SPSR;
            if (ack_ok && !bus.m_dat_i[0]) state_d = S_RX;
         end
         S_RX: begin
            acc_req = 1'b1; acc_adr = ADR_SPDR;
            if (ack_ok) begin
               if (k_q[2])                             state_d = S_OUT;
               else if (k_q == 3'd3 && rem_q == '0)    state_d = S_SS_OFF;
               else                                    state_d = S_TX;
            end
         end
         S_OUT: begin
            if (rd_ready_i) state_d = (rem_q == LEN_W'(1)) ? S_SS_OFF : S_TX;
         end
         S_SS_OFF: begin
            acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SS; acc_dat = 8'h00;
            if (ack_ok) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_CFG_SPCR;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_CFG_SPCR;
      else       state_q <= state_d;
   end

   // cyc drops on the ack edge; the next state's access starts one cycle later
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         adr_q <= 3'd0;
         dat_q <= 8'h00;
      end else if (cyc_q) begin
         if (bus.m_ack_i) cyc_q <= 1'b0;
      end else if (acc_req) begin
         cyc_q <= 1'b1;
         we_q  <= acc_we;
         adr_q <= acc_adr;
         dat_q <= acc_dat;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q    <= 24'h0;
         rem_q     <= '0;
         k_q       <= 3'd0;
         rd_data_q <= 8'h00;
      end else begin
         if (state_q == S_IDLE && req_valid_i) begin
            addr_q <= req_addr_i;
            rem_q  <= req_len_i;
            k_q    <= 3'd0;
         end
         if (state_q == S_RX && ack_ok) begin
            if (k_q[2]) rd_data_q <= bus.m_dat_i;
            else        k_q       <= k_q + 3'd1;
         end
         if (state_q == S_OUT && rd_ready_i) rem_q <= rem_q - LEN_W'(1);
      end
   end

   assign bus.m_cyc_o = cyc_q;
   assign bus.m_stb_o = cyc_q;
   assign bus.m_we_o  = we_q;
   assign bus.m_adr_o = adr_q;
   assign bus.m_dat_o = dat_q;

   assign req_ready_o = (state_q == S_IDLE);
   assign rd_valid_o  = (state_q == S_OUT);
   assign rd_data_o   = rd_data_q;
   assign done_o      = (state_q == S_DONE);

endmodule
